// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: arbiter FSM encoding and default bus widths.
package pipeline_pkg;

   localparam int ADDR_W_DEFAULT = 32;
   localparam int DATA_W_DEFAULT = 32;
   localparam int STARVE_CNT_W   = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_IF  = 2'd1,
      GNT_MEM = 2'd2
   } arb_state_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive MEM grants that overtook a waiting fetch.
module starve_counter #(
   parameter int MAX = 4,
   parameter int W   = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] count;

   // Clear wins over increment so an IF grant always restarts the window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX_V)) begin
         count <= count + 1'b1;
      end
   end

   assign at_max = (count == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and MEM stage requests onto one single-ported memory,
// MEM first unless the fetch side has been overtaken STARVE_MAX times.
module mem_port_arbiter
   import pipeline_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEFAULT,
   parameter int DATA_W     = DATA_W_DEFAULT,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ack,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ready,
   output logic              stall_if,
   output logic              stall_mem
);

   arb_state_t state;
   logic       can_grant;
   logic       pick_if;
   logic       pick_mem;
   logic       starved;

   // The ack cycle is spent idle so a requester still showing its old
   // request while it sees the ack is not granted a second time.
   always_comb begin
      can_grant = (state == IDLE) && !if_ack && !mem_ack;
      pick_if   = can_grant && if_req && (!mem_req || starved);
      pick_mem  = can_grant && mem_req && !pick_if;
   end

   starve_counter #(
      .MAX (STARVE_MAX),
      .W   (STARVE_CNT_W)
   ) u_starve (
      .clk    (clk),
      .rst    (rst),
      .inc    (pick_mem && if_req),
      .clr    (pick_if),
      .at_max (starved)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ram_req   <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
         if_ack    <= 1'b0;
         mem_ack   <= 1'b0;
      end else begin
         if_ack  <= 1'b0;
         mem_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_if) begin
                  ram_req  <= 1'b1;
                  ram_we   <= 1'b0;
                  ram_addr <= if_addr;
                  state    <= GNT_IF;
               end else if (pick_mem) begin
                  ram_req   <= 1'b1;
                  ram_we    <= mem_we;
                  ram_addr  <= mem_addr;
                  ram_wdata <= mem_wdata;
                  state     <= GNT_MEM;
               end
            end
            GNT_IF: begin
               if (ram_ready) begin
                  ram_req  <= 1'b0;
                  if_rdata <= ram_rdata;
                  if_ack   <= 1'b1;
                  state    <= IDLE;
               end
            end
            GNT_MEM: begin
               if (ram_ready) begin
                  ram_req <= 1'b0;
                  if (!ram_we) begin
                     mem_rdata <= ram_rdata;
                  end
                  mem_ack <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               ram_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign stall_if  = if_req  & ~if_ack;
   assign stall_mem = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, corner-case
// sequences and a randomized run against a transaction-level memory model.
module tb_mem_port_arbiter;

   localparam int SMAX = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        mem_req = 1'b0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        ram_req;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;
   logic        ram_ready = 1'b0;
   logic        stall_if;
   logic        stall_mem;

   int total = 0;
   int bad = 0;

   int cur_lat = 1;
   bit rand_lat = 1'b0;
   bit stray_ready = 1'b0;
   int ram_wait = 0;
   bit ready_was = 1'b0;

   logic [31:0] ram_store [logic [31:0]];
   logic [31:0] ref_mem   [logic [31:0]];

   typedef struct {
      bit          is_mem;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] exp_rdata;
      int          exp_cycles;
   } vec_t;

   vec_t vecs [7];

   mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .ram_req   (ram_req),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .ram_ready (ram_ready),
      .stall_if  (stall_if),
      .stall_mem (stall_mem)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] default_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   function automatic logic [31:0] ram_read(input logic [31:0] a);
      if (ram_store.exists(a)) return ram_store[a];
      return default_word(a);
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return default_word(a);
   endfunction

   function automatic logic [31:0] rand_addr();
      return 32'h100 + ($urandom_range(0, 15) << 2);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: memory responds 2ns after the edge to whatever the arbiter
   // now requests; ready_was records the ready level the edge just sampled.
   task automatic step_cycle();
      @(posedge clk);
      ready_was = ram_ready;
      #2;
      if (ram_req) begin
         ram_wait++;
         if (ram_wait == 1 && rand_lat) cur_lat = $urandom_range(1, 4);
         if (ram_wait >= cur_lat) begin
            ram_ready = 1'b1;
            ram_rdata = ram_read(ram_addr);
            if (ram_we) ram_store[ram_addr] = ram_wdata;
         end else begin
            ram_ready = 1'b0;
            ram_rdata = $urandom;
         end
      end else begin
         ram_wait  = 0;
         ram_ready = stray_ready;
         ram_rdata = 32'hBAD0_BAD0;
      end
   endtask

   task automatic apply_reset();
      if_req = 1'b0;
      mem_req = 1'b0;
      mem_we = 1'b0;
      stray_ready = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("rst_ram_req", 32'(ram_req), 0);
      checkOutput("rst_ram_we", 32'(ram_we), 0);
      checkOutput("rst_if_ack", 32'(if_ack), 0);
      checkOutput("rst_mem_ack", 32'(mem_ack), 0);
      checkOutput("rst_ram_addr", ram_addr, 0);
      checkOutput("rst_ram_wdata", ram_wdata, 0);
      checkOutput("rst_if_rdata", if_rdata, 0);
      checkOutput("rst_mem_rdata", mem_rdata, 0);
      step_cycle();
      step_cycle();
      rst = 1'b1;
   endtask

   task automatic applyStimulus(input vec_t v);
      int  cycles;
      bit  got;
      bit  granted;
      cur_lat  = v.lat;
      rand_lat = 1'b0;
      if (v.is_mem) begin
         mem_req = 1'b1;
         mem_we = v.we;
         mem_addr = v.addr;
         mem_wdata = v.wdata;
      end else begin
         if_req = 1'b1;
         if_addr = v.addr;
      end
      #1;
      checkOutput("vec_stall_pre", 32'(v.is_mem ? stall_mem : stall_if), 1);
      cycles = 0;
      got = 1'b0;
      granted = 1'b0;
      while (!got && cycles < 30) begin
         step_cycle();
         cycles++;
         if (!granted && ram_req) begin
            granted = 1'b1;
            checkOutput("vec_grant_we", 32'(ram_we), 32'(v.we));
            checkOutput("vec_grant_addr", ram_addr, v.addr);
            if (v.we) checkOutput("vec_grant_wdata", ram_wdata, v.wdata);
         end
         got = v.is_mem ? mem_ack : if_ack;
      end
      checkOutput("vec_ack_seen", 32'(got), 1);
      checkOutput("vec_ack_cycles", cycles, v.exp_cycles);
      checkOutput("vec_rdata", v.is_mem ? mem_rdata : if_rdata, v.exp_rdata);
      checkOutput("vec_other_ack", 32'(v.is_mem ? if_ack : mem_ack), 0);
      checkOutput("vec_stall_at_ack", 32'(v.is_mem ? stall_mem : stall_if), 0);
      if_req = 1'b0;
      mem_req = 1'b0;
      mem_we = 1'b0;
      step_cycle();
      checkOutput("vec_ack_pulse", 32'(v.is_mem ? mem_ack : if_ack), 0);
      checkOutput("vec_ram_req_idle", 32'(ram_req), 0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          n;
      int          stable;
      int          acks;
      int          order [$];
      int          when  [$];
      int          exp_order [6];
      vec_t        v;
      int          phase;
      bit          busy_mem;
      bit          busy_we;
      logic [31:0] busy_addr;
      logic [31:0] busy_wdata;
      int          exp_starve;
      bit          exp_if_ack;
      bit          exp_mem_ack;
      logic [31:0] exp_if_rdata;
      logic [31:0] exp_mem_rdata;

      vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        1, 32'h2002000A, 2};
      vecs[1] = '{1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1, 32'h0,        2};
      vecs[2] = '{1'b1, 1'b0, 32'h40, 32'h0,        2, 32'hDEADBEEF, 3};
      vecs[3] = '{1'b0, 1'b0, 32'h40, 32'h0,        3, 32'hDEADBEEF, 4};
      vecs[4] = '{1'b1, 1'b1, 32'h80, 32'h12345678, 1, 32'hDEADBEEF, 2};
      vecs[5] = '{1'b1, 1'b0, 32'h10, 32'h0,        4, 32'h2002000A, 5};
      vecs[6] = '{1'b0, 1'b0, 32'h80, 32'h0,        1, 32'h12345678, 2};
      ram_store[32'h10] = 32'h2002000A;

      #1;
      apply_reset();

      for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

      // Both requesters held continuously: MEM twice, then the fetch.
      exp_order = '{1, 1, 0, 1, 1, 0};
      cur_lat = 1;
      if_req = 1'b1;
      if_addr = 32'h200;
      mem_req = 1'b1;
      mem_we = 1'b0;
      mem_addr = 32'h300;
      for (int c = 0; c < 40 && order.size() < 6; c++) begin
         step_cycle();
         if (if_ack || mem_ack) begin
            order.push_back(mem_ack ? 1 : 0);
            when.push_back(c);
            if (order.size() == 1) checkOutput("cont_loser_stall", 32'(stall_if), 1);
         end
      end
      if_req = 1'b0;
      mem_req = 1'b0;
      checkOutput("cont_count", order.size(), 6);
      for (int k = 0; k < order.size() && k < 6; k++) begin
         checkOutput($sformatf("cont_order%0d", k), order[k], exp_order[k]);
         if (k > 0) checkOutput($sformatf("cont_gap%0d", k), when[k] - when[k-1], 3);
      end
      step_cycle();

      // Slow memory: request must hold steady through the whole wait.
      cur_lat = 5;
      mem_req = 1'b1;
      mem_we = 1'b0;
      mem_addr = 32'h44;
      stable = 0;
      acks = 0;
      for (int c = 0; c < 12; c++) begin
         step_cycle();
         if (ram_req && ram_addr == 32'h44 && !mem_ack) stable++;
         if (mem_ack) begin
            acks++;
            checkOutput("lat_rdata", mem_rdata, default_word(32'h44));
            mem_req = 1'b0;
         end
      end
      checkOutput("lat_stable", stable, 5);
      checkOutput("lat_acks", acks, 1);

      // Reset during a MEM grant with the starve counter already raised.
      cur_lat = 1;
      if_req = 1'b1;
      if_addr = 32'h204;
      mem_req = 1'b1;
      mem_we = 1'b0;
      mem_addr = 32'h48;
      n = 0;
      while (!mem_ack && n < 10) begin
         step_cycle();
         n++;
      end
      checkOutput("rmt_first_ack", 32'(mem_ack), 1);
      cur_lat = 10;
      step_cycle();
      step_cycle();
      checkOutput("rmt_regrant_req", 32'(ram_req), 1);
      checkOutput("rmt_regrant_addr", ram_addr, 32'h48);
      step_cycle();
      rst = 1'b0;
      #1;
      checkOutput("rmt_ram_req_drop", 32'(ram_req), 0);
      checkOutput("rmt_ram_addr", ram_addr, 0);
      checkOutput("rmt_ram_we", 32'(ram_we), 0);
      checkOutput("rmt_mem_rdata", mem_rdata, 0);
      checkOutput("rmt_if_rdata", if_rdata, 0);
      cur_lat = 1;
      for (int c = 0; c < 2; c++) begin
         step_cycle();
         checkOutput("rmt_no_ack", 32'(mem_ack | if_ack | ram_req), 0);
      end
      rst = 1'b1;
      n = 0;
      while (!(if_ack || mem_ack) && n < 10) begin
         step_cycle();
         n++;
      end
      checkOutput("rmt_cold_mem_wins", 32'(mem_ack), 1);
      checkOutput("rmt_cold_if_ack", 32'(if_ack), 0);
      checkOutput("rmt_cold_cycles", n, 2);
      checkOutput("rmt_cold_rdata", mem_rdata, default_word(32'h48));
      if_req = 1'b0;
      mem_req = 1'b0;
      step_cycle();

      // Ready pulses while idle must be ignored.
      stray_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step_cycle();
         checkOutput("stray_ram_req", 32'(ram_req), 0);
         checkOutput("stray_acks", 32'(if_ack | mem_ack), 0);
         checkOutput("stray_if_rdata", if_rdata, 0);
         checkOutput("stray_mem_rdata", mem_rdata, default_word(32'h48));
      end
      stray_ready = 1'b0;
      v = '{1'b0, 1'b0, 32'h10, 32'h0, 1, 32'h2002000A, 2};
      applyStimulus(v);

      // Randomized traffic against a transaction-level scoreboard.
      step_cycle();
      apply_reset();
      ram_store.delete();
      ref_mem.delete();
      rand_lat = 1'b1;
      phase = 0;
      exp_starve = 0;
      exp_if_rdata = '0;
      exp_mem_rdata = '0;
      busy_mem = 1'b0;
      busy_we = 1'b0;
      busy_addr = '0;
      busy_wdata = '0;
      for (int i = 0; i < 1500; i++) begin
         bit if_done;
         bit mem_done;
         step_cycle();
         exp_if_ack = 1'b0;
         exp_mem_ack = 1'b0;
         if_done = 1'b0;
         mem_done = 1'b0;
         if (phase == 0) begin
            if (if_req || mem_req) begin
               busy_mem = mem_req && !(if_req && exp_starve == SMAX);
               if (busy_mem) begin
                  busy_we = mem_we;
                  busy_addr = mem_addr;
                  busy_wdata = mem_wdata;
                  if (if_req) exp_starve = (exp_starve < SMAX) ? exp_starve + 1 : SMAX;
               end else begin
                  busy_we = 1'b0;
                  busy_addr = if_addr;
                  exp_starve = 0;
               end
               checkOutput("rnd_grant_req", 32'(ram_req), 1);
               checkOutput("rnd_grant_addr", ram_addr, busy_addr);
               checkOutput("rnd_grant_we", 32'(ram_we), 32'(busy_we));
               if (busy_we) checkOutput("rnd_grant_wdata", ram_wdata, busy_wdata);
               phase = 1;
            end else begin
               checkOutput("rnd_idle_req", 32'(ram_req), 0);
            end
         end else if (phase == 1) begin
            if (ready_was) begin
               if (busy_mem) begin
                  exp_mem_ack = 1'b1;
                  mem_done = 1'b1;
                  if (busy_we) ref_mem[busy_addr] = busy_wdata;
                  else exp_mem_rdata = ref_read(busy_addr);
               end else begin
                  exp_if_ack = 1'b1;
                  if_done = 1'b1;
                  exp_if_rdata = ref_read(busy_addr);
               end
               checkOutput("rnd_done_req", 32'(ram_req), 0);
               phase = 2;
            end else begin
               checkOutput("rnd_wait_req", 32'(ram_req), 1);
               checkOutput("rnd_wait_addr", ram_addr, busy_addr);
            end
         end else begin
            checkOutput("rnd_cool_req", 32'(ram_req), 0);
            phase = 0;
         end
         checkOutput("rnd_if_ack", 32'(if_ack), 32'(exp_if_ack));
         checkOutput("rnd_mem_ack", 32'(mem_ack), 32'(exp_mem_ack));
         checkOutput("rnd_if_rdata", if_rdata, exp_if_rdata);
         checkOutput("rnd_mem_rdata", mem_rdata, exp_mem_rdata);
         if (if_done || !if_req) begin
            if_req = 1'($urandom_range(0, 1));
            if_addr = rand_addr();
         end
         if (mem_done || !mem_req) begin
            mem_req = 1'($urandom_range(0, 1));
            mem_we = 1'($urandom_range(0, 1));
            mem_addr = rand_addr();
            mem_wdata = $urandom;
         end
         stray_ready = ($urandom_range(0, 3) == 0);
         #1;
         checkOutput("rnd_stall_if", 32'(stall_if), 32'(if_req && !exp_if_ack));
         checkOutput("rnd_stall_mem", 32'(stall_mem), 32'(mem_req && !exp_mem_ack));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
